// File: rtl/cla_pkg.sv
// Shared carry-lookahead helpers: 4-bit group propagate/generate and in-group carries.
package cla_pkg;

    localparam int GROUP_W = 4;

    typedef struct packed {
        logic pm;
        logic gm;
    } group_pg_t;

    function automatic group_pg_t group_pg(input logic [GROUP_W-1:0] p,
                                           input logic [GROUP_W-1:0] g);
        group_pg_t r;
        r.pm = &p;
        r.gm = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        return r;
    endfunction

    // Carries into bits 0..3 of one group, all expanded from c0 (no ripple).
    function automatic logic [GROUP_W-1:0] group_carries(input logic [GROUP_W-1:0] p,
                                                         input logic [GROUP_W-1:0] g,
                                                         input logic               c0);
        logic [GROUP_W-1:0] c;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        return c;
    endfunction

endpackage

// File: rtl/cla_seg.sv
// Combinational SEG_W-bit segment adder: 4-bit P/G groups joined by a second lookahead level.
module cla_seg
    import cla_pkg::*;
#(
    parameter int SEG_W = 16
) (
    input  logic [SEG_W-1:0] a_seg,
    input  logic [SEG_W-1:0] b_seg,
    input  logic             c_in,
    output logic [SEG_W-1:0] sum,
    output logic             c_out,
    output logic             c_msb_in
);

    localparam int NG = SEG_W / GROUP_W;

    logic [SEG_W-1:0] p;
    logic [SEG_W-1:0] g;
    logic [SEG_W-1:0] c;
    logic [NG-1:0]    gp;
    logic [NG-1:0]    gg;
    logic [NG:0]      gc;

    assign p = a_seg ^ b_seg;
    assign g = a_seg & b_seg;

    for (genvar j = 0; j < NG; j++) begin : g_grp
        group_pg_t pg;
        assign pg    = group_pg(p[j*GROUP_W +: GROUP_W], g[j*GROUP_W +: GROUP_W]);
        assign gp[j] = pg.pm;
        assign gg[j] = pg.gm;
        assign c[j*GROUP_W +: GROUP_W] =
            group_carries(p[j*GROUP_W +: GROUP_W], g[j*GROUP_W +: GROUP_W], gc[j]);
    end

    // Each group carry is a flat sum of products over lower groups and c_in.
    always_comb begin : lookahead
        logic term;
        logic carry;
        gc = '0;
        gc[0] = c_in;
        for (int j = 1; j <= NG; j++) begin
            term = c_in;
            for (int k = 0; k < j; k++) term = term & gp[k];
            carry = term;
            for (int k = 0; k < j; k++) begin
                term = gg[k];
                for (int m = k + 1; m < j; m++) term = term & gp[m];
                carry = carry | term;
            end
            gc[j] = carry;
        end
    end

    assign sum      = p ^ c;
    assign c_out    = gc[NG];
    assign c_msb_in = c[SEG_W-1];

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined CLA adder/subtractor, one segment per stage with a valid/ready handshake.
// Optional macro CLA_PIPE_SAT_EN adds a per-beat 'sat' input that clamps overflowing results.
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
`ifdef CLA_PIPE_SAT_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int SEG_W = WIDTH / STAGES;

    typedef struct packed {
        logic             valid;
`ifdef CLA_PIPE_SAT_EN
        logic             sat;
`endif
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] s;
        logic             carry;
        logic             ovf;
    } stage_t;

    stage_t st [STAGES];
    stage_t head;
    logic   adv;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Subtraction is A + ~B + 1, so B is inverted once before the pipe.
    always_comb begin
        head       = '0;
        head.valid = in_valid;
        head.a     = a;
        head.b     = sub ? ~b : b;
        head.carry = sub ? 1'b1 : cin;
`ifdef CLA_PIPE_SAT_EN
        head.sat   = sat;
`endif
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        stage_t           src;
        stage_t           nxt;
        logic [SEG_W-1:0] seg_sum;
        logic             seg_cout;
        logic             seg_cmsb;

        if (k == 0) begin : g_head
            assign src = head;
        end else begin : g_body
            assign src = st[k-1];
        end

        cla_seg #(.SEG_W(SEG_W)) u_seg (
            .a_seg    (src.a[k*SEG_W +: SEG_W]),
            .b_seg    (src.b[k*SEG_W +: SEG_W]),
            .c_in     (src.carry),
            .sum      (seg_sum),
            .c_out    (seg_cout),
            .c_msb_in (seg_cmsb)
        );

        // NOTE: start from a full default so every field is assigned on every path (no latch).
        always_comb begin
            nxt                      = src;
            nxt.s[k*SEG_W +: SEG_W]  = seg_sum;
            nxt.carry                = seg_cout;
            nxt.ovf                  = seg_cout ^ seg_cmsb;
`ifdef CLA_PIPE_SAT_EN
            if (k == STAGES - 1 && nxt.sat && nxt.ovf)
                nxt.s = nxt.a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
        end

        // NOTE: data/carry fields are cleared too so s/cout/ovf read 0 out of reset;
        // non-blocking updates keep every stage sampling its predecessor's old value.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                st[k] <= '0;
            end else if (adv) begin
                st[k] <= nxt;
            end
        end
    end

    assign out_valid = st[STAGES-1].valid;
    assign s         = st[STAGES-1].s;
    assign cout      = st[STAGES-1].carry;
    assign ovf       = st[STAGES-1].ovf;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder: directed corners, stall stream, random stream, mid-run reset.
`timescale 1ns/1ps
module tb_cla_pipe_adder;

    localparam int W = 32;
    localparam int S = 2;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         sub       = 1'b0;
    logic         cin       = 1'b0;
    logic         out_ready = 1'b1;
    logic         sat_bit   = 1'b0;
    logic [W-1:0] a         = '0;
    logic [W-1:0] b         = '0;
    logic         in_ready;
    logic         out_valid;
    logic         cout;
    logic         ovf;
    logic [W-1:0] s;

    always #5 clk = ~clk;

    cla_pipe_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .cin       (cin),
`ifdef CLA_PIPE_SAT_EN
        .sat       (sat_bit),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf)
    );

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } exp_t;

    exp_t           q[$];
    int             checks    = 0;
    int             errors    = 0;
    logic           hold_pend = 1'b0;
    logic [W+2:0]   hold_val  = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: exact signed and unsigned arithmetic on wide integers.
    function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                                   input logic tsub, input logic tcin, input logic tsat);
        exp_t     e;
        longint   sa, sb, sres, smax, smin;
        logic [W:0] ures;
        sa   = longint'($signed(ta));
        sb   = longint'($signed(tb_));
        smax = (longint'(1) <<< (W - 1)) - 1;
        smin = -(longint'(1) <<< (W - 1));
        if (tsub) begin
            sres = sa - sb;
            ures = {1'b0, ta} - {1'b0, tb_};
            e.c  = (ta >= tb_);
        end else begin
            sres = sa + sb + longint'(tcin);
            ures = {1'b0, ta} + {1'b0, tb_} + {{W{1'b0}}, tcin};
            e.c  = ures[W];
        end
        e.s = ures[W-1:0];
        e.o = (sres > smax) || (sres < smin);
        if (tsat && e.o) e.s = (sres < 0) ? smin[W-1:0] : smax[W-1:0];
        return e;
    endfunction

    task automatic rand_ops();
        a   = $urandom;
        b   = $urandom;
        sub = 1'($urandom_range(0, 1));
        cin = 1'($urandom_range(0, 1));
`ifdef CLA_PIPE_SAT_EN
        sat_bit = 1'($urandom_range(0, 1));
`endif
    endtask

    // One clock of the streaming scoreboard; inputs are already stable when called.
    task automatic tick(output bit acc);
        exp_t e;
        @(negedge clk);
        if (hold_pend) check("hold_stable", {out_valid, cout, ovf, s}, hold_val);
        if (out_valid && !out_ready) check("stall_in_ready", in_ready, 0);
        hold_pend = out_valid && !out_ready;
        hold_val  = {out_valid, cout, ovf, s};
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("spurious_out_valid", out_valid, 0);
            end else begin
                e = q.pop_front();
                check("stream_s", s, e.s);
                check("stream_cout", cout, e.c);
                check("stream_ovf", ovf, e.o);
            end
        end
        acc = in_valid && in_ready;
        if (acc) q.push_back(model(a, b, sub, cin, sat_bit));
        @(posedge clk);
        #1;
    endtask

    task automatic directed(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                            input logic tsub, input logic tcin,
                            input logic [W-1:0] es, input logic ec, input logic eo);
        a = ta; b = tb_; sub = tsub; cin = tcin;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check({tag, "_in_ready"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 1; i < S; i++) begin
            check({tag, "_early"}, out_valid, 0);
            @(posedge clk); #1;
        end
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_s"}, s, es);
        check({tag, "_cout"}, cout, ec);
        check({tag, "_ovf"}, ovf, eo);
        @(posedge clk); #1;
        check({tag, "_drained"}, out_valid, 0);
    endtask

    initial begin
        bit acc;
        int sent;

        // Reset state
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_s", s, 0);
        check("rst_cout", cout, 0);
        check("rst_ovf", ovf, 0);
        #21 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", in_ready, 1);

        // Directed corners
        directed("add_wrap",    32'hFFFF_FFFF, 32'h0000_0001, 0, 0, 32'h0000_0000, 1, 0);
        directed("add_ovf",     32'h7FFF_FFFF, 32'h0000_0001, 0, 0, 32'h8000_0000, 0, 1);
        directed("sub_neg",     32'h0000_0005, 32'h0000_0007, 1, 0, 32'hFFFF_FFFE, 0, 0);
        directed("ones_cin",    32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1, 32'hFFFF_FFFF, 1, 0);
        directed("sub_equal",   32'h1234_5678, 32'h1234_5678, 1, 0, 32'h0000_0000, 1, 0);
        directed("sub_cin_ign", 32'h0000_000A, 32'h0000_0003, 1, 1, 32'h0000_0007, 1, 0);
        directed("sub_ovf",     32'h8000_0000, 32'h0000_0001, 1, 0, 32'h7FFF_FFFF, 1, 1);
        directed("seg_carry",   32'h0000_FFFF, 32'h0000_0001, 0, 0, 32'h0001_0000, 0, 0);
`ifdef CLA_PIPE_SAT_EN
        sat_bit = 1'b1;
        directed("sat_pos", 32'h7FFF_FFFF, 32'h0000_0001, 0, 0, 32'h7FFF_FFFF, 0, 1);
        directed("sat_neg", 32'h8000_0000, 32'h0000_0001, 1, 0, 32'h8000_0000, 1, 1);
        directed("sat_noovf", 32'h0000_0005, 32'h0000_0007, 1, 0, 32'hFFFF_FFFE, 0, 0);
        sat_bit = 1'b0;
`endif

        // 8 back-to-back beats with the sink stalled for cycles 3..6
        hold_pend = 1'b0;
        sent      = 0;
        rand_ops();
        in_valid = 1'b1;
        for (int cyc = 0; cyc < 60 && sent < 8; cyc++) begin
            out_ready = !(cyc >= 3 && cyc <= 6);
            tick(acc);
            if (acc) begin
                sent++;
                rand_ops();
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 50 && q.size() > 0; cyc++) tick(acc);
        check("stall_sent", sent, 8);
        check("stall_drained", q.size(), 0);

        // Long random stream with random valid/ready
        sent = 0;
        rand_ops();
        for (int cyc = 0; cyc < 6000 && sent < 1000; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            tick(acc);
            if (acc) begin
                sent++;
                rand_ops();
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 50 && q.size() > 0; cyc++) tick(acc);
        check("rand_sent", sent, 1000);
        check("rand_drained", q.size(), 0);
`ifdef CLA_PIPE_SAT_EN
        sat_bit = 1'b0;
`endif

        // Reset with two beats in flight
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a = 32'h0000_0011; b = 32'h0000_0022; sub = 1'b0; cin = 1'b0;
        @(posedge clk); #1;
        a = 32'h0000_0033;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_s", s, 0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        for (int i = 0; i < 2 * S + 2; i++) begin
            @(negedge clk);
            check("midrst_no_stale", out_valid, 0);
        end
        @(posedge clk); #1;
        directed("post_rst", 32'h0000_1000, 32'h0000_0234, 0, 1, 32'h0000_1235, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
